// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared state encoding, opcode and ALU-control constants for multicycle_ctrl
//   Used by: multicycle_ctrl (top) and mctrl_decode (combinational opcode decode).
package mctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALTED,
      S_TRAP
   } state_t;

   localparam logic [5:0] OP_AND  = 6'b000000;
   localparam logic [5:0] OP_OR   = 6'b000001;
   localparam logic [5:0] OP_ADD  = 6'b000010;
   localparam logic [5:0] OP_SUB  = 6'b000110;
   localparam logic [5:0] OP_SLT  = 6'b000111;
   localparam logic [5:0] OP_NOR  = 6'b001100;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: combinational opcode decode for the multicycle controller
//   opcode  in  [5:0] instruction opcode (IR[31:26])
//   alu_ctl out [3:0] ALU select; the low opcode nibble is the ALU encoding
//   legal   out       opcode is one of the supported ALU operations
//   is_halt out       opcode is OP_HALT
module mctrl_decode
   import mctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output logic [3:0] alu_ctl,
   output logic       legal,
   output logic       is_halt
);

   always_comb begin
      alu_ctl = opcode[3:0];
      legal   = opcode inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};
      is_halt = opcode == OP_HALT;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXECUTE/WRITEBACK control FSM for a multicycle datapath
//   CLK, RESET       clock; asynchronous active-high reset
//   run              level: 1 = keep executing, 0 = stop after the current instruction
//   imem_ready       instruction memory data valid (only looked at in FETCH)
//   opcode, rd       IR fields [31:26] and [15:11]
//   imem_req         fetch request (high for every FETCH cycle)
//   ir_write/pc_write IR load and PC+4 strobes on the accepted fetch cycle
//   rf_read, alu_latch, reg_write  one-cycle datapath strobes
//   alu_ctl          ALU select, held from one decode to the next
//   busy, halted, trap  status; HALTED and TRAP are sticky until RESET
//   retired          completed-writeback count when MCTRL_PERF_CNT_EN is defined, else 0
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             run,
   input  logic             imem_ready,
   input  logic [5:0]       opcode,
   input  logic [4:0]       rd,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             rf_read,
   output logic [3:0]       alu_ctl,
   output logic             alu_latch,
   output logic             reg_write,
   output logic             busy,
   output logic             halted,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   state_t     r_state;
   logic       r_imem_req;
   logic       r_rf_read;
   logic       r_alu_latch;
   logic       r_reg_write;
   logic       r_busy;
   logic       r_halted;
   logic       r_trap;
   logic [3:0] r_alu_ctl;
   logic [3:0] w_alu_ctl;
   logic       w_legal;
   logic       w_is_halt;

   mctrl_decode u_decode (
      .opcode  (opcode),
      .alu_ctl (w_alu_ctl),
      .legal   (w_legal),
      .is_halt (w_is_halt)
   );

   // Every strobe is registered alongside the state it belongs to, so it is
   // high for exactly the cycle spent in that state.
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         r_state     <= S_IDLE;
         r_imem_req  <= 1'b0;
         r_rf_read   <= 1'b0;
         r_alu_latch <= 1'b0;
         r_reg_write <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_trap      <= 1'b0;
         r_alu_ctl   <= ALU_AND;
      end else begin
         r_rf_read   <= 1'b0;
         r_alu_latch <= 1'b0;
         r_reg_write <= 1'b0;
         case (r_state)
            S_IDLE:
               if (run) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_busy     <= 1'b1;
               end
            S_FETCH:
               if (imem_ready) begin
                  r_state    <= S_DECODE;
                  r_imem_req <= 1'b0;
                  r_rf_read  <= 1'b1;
               end
            S_DECODE:
               if (w_is_halt) begin
                  r_state  <= S_HALTED;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else if (w_legal) begin
                  r_state     <= S_EXECUTE;
                  r_alu_ctl   <= w_alu_ctl;
                  r_alu_latch <= 1'b1;
               end else begin
                  r_state <= S_TRAP;
                  r_busy  <= 1'b0;
                  r_trap  <= 1'b1;
               end
            S_EXECUTE: begin
               r_state     <= S_WRITEBACK;
               r_reg_write <= rd != 5'd0;
            end
            S_WRITEBACK:
               if (run) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            default: ;
         endcase
      end

   // The fetch is accepted in the same cycle memory reports ready; r_imem_req
   // is only high in FETCH, so stray imem_ready elsewhere has no effect.
   assign imem_req  = r_imem_req;
   assign ir_write  = r_imem_req & imem_ready;
   assign pc_write  = r_imem_req & imem_ready;
   assign rf_read   = r_rf_read;
   assign alu_latch = r_alu_latch;
   assign reg_write = r_reg_write;
   assign alu_ctl   = r_alu_ctl;
   assign busy      = r_busy;
   assign halted    = r_halted;
   assign trap      = r_trap;

`ifdef MCTRL_PERF_CNT_EN
   logic [CNT_W-1:0] r_retired;
   always_ff @(posedge CLK or posedge RESET)
      if (RESET)
         r_retired <= '0;
      else if (r_state == S_WRITEBACK)
         r_retired <= r_retired + CNT_W'(1);
   assign retired = r_retired;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl with a small IR/memory model
module tb_multicycle_ctrl;

   localparam int K_ALU  = 0;
   localparam int K_HALT = 1;
   localparam int K_TRAP = 2;

   typedef struct packed {
      logic [31:0] cyc;
      logic [5:0]  s;
      logic [3:0]  alu;
      logic        bz;
      logic        h;
      logic        t;
   } ev_t;

   logic        CLK, RESET, run, imem_ready;
   logic [5:0]  opcode;
   logic [4:0]  rd;
   logic        imem_req, ir_write, pc_write, rf_read, alu_latch, reg_write;
   logic        busy, halted, trap;
   logic [3:0]  alu_ctl;
   logic [15:0] retired;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   ev_t  q[$];

   logic [5:0] p_op[16];
   logic [4:0] p_rd[16];
   int         p_w[16];
   int         p_k[16];
   logic [3:0] p_alu[16];
   int         mi = 0;
   int         wcnt = 0;
   bit         fetched = 0;
   logic [3:0] cur_alu = 4'b0000;

   multicycle_ctrl #(.CNT_W(16)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .run        (run),
      .imem_ready (imem_ready),
      .opcode     (opcode),
      .rd         (rd),
      .imem_req   (imem_req),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .rf_read    (rf_read),
      .alu_ctl    (alu_ctl),
      .alu_latch  (alu_latch),
      .reg_write  (reg_write),
      .busy       (busy),
      .halted     (halted),
      .trap       (trap),
      .retired    (retired)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input logic [5:0] s, input logic [3:0] a,
                              input logic bz, input logic h, input logic t);
      mk = {32'(c), s, a, bz, h, t};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory + IR model: ready is 1 except for the programmed wait cycles of a
   // fetch; the accepted word appears on opcode/rd in the following cycle.
   initial begin
      imem_ready = 1'b1;
      opcode = 6'b0;
      rd = 5'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (fetched) begin
            opcode = p_op[mi];
            rd = p_rd[mi];
            mi++;
            wcnt = 0;
            fetched = 0;
         end
         if (imem_req && wcnt < p_w[mi]) begin
            imem_ready = 1'b0;
            wcnt++;
         end else begin
            imem_ready = 1'b1;
            fetched = imem_req;
         end
      end
   end

   // Monitor: any strobe, or halted/trap rising, is an output event to be matched.
   initial begin
      ev_t act, e;
      logic [5:0] s;
      logic prev_ht;
      prev_ht = 1'b0;
      forever begin
         @(negedge CLK);
         s = {imem_req, ir_write, pc_write, rf_read, alu_latch, reg_write};
         if (s != 6'b0 || ((halted | trap) && !prev_ht)) begin
            act = mk(cyc, s, alu_ctl, busy, halted, trap);
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event cyc=%0d strobes=%b alu=%b busy=%b halted=%b trap=%b required=none",
                        act.cyc, act.s, act.alu, act.bz, act.h, act.t);
            end else begin
               e = q.pop_front();
               if (act !== e) begin
                  failures++;
                  $display("FAIL event cyc=%0d strobes=%b alu=%b busy=%b halted=%b trap=%b required cyc=%0d strobes=%b alu=%b busy=%b halted=%b trap=%b",
                           act.cyc, act.s, act.alu, act.bz, act.h, act.t, e.cyc, e.s, e.alu, e.bz, e.h, e.t);
               end
            end
         end
         prev_ht = halted | trap;
      end
   end

   task automatic ld(input int i, input logic [5:0] op, input logic [4:0] r, input int w,
                     input int k, input logic [3:0] a);
      p_op[i] = op;
      p_rd[i] = r;
      p_w[i] = w;
      p_k[i] = k;
      p_alu[i] = a;
   endtask

   task automatic do_reset();
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      run = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      cur_alu = 4'b0000;
   endtask

   task automatic drain(input string name);
      for (int t = 0; t < 300 && q.size() > 0; t++) @(posedge CLK);
      @(negedge CLK);
      chk(name, 32'(q.size()), 32'd0);
      q.delete();
   endtask

   // mode 0: drop run in the last instruction's EXECUTE; 1: leave run high;
   // 2: assert RESET in the last instruction's EXECUTE.
   task automatic go(input int n, input int mode);
      int b, w, ex;
      logic [3:0] a;
      @(negedge CLK);
      mi = 0;
      wcnt = 0;
      fetched = 0;
      a = cur_alu;
      ex = 0;
      @(posedge CLK);
      #1;
      run = 1'b1;
      b = cyc + 1;
      for (int i = 0; i < n; i++) begin
         w = p_w[i];
         for (int j = 0; j < w; j++) q.push_back(mk(b + j, 6'b100000, a, 1'b1, 1'b0, 1'b0));
         q.push_back(mk(b + w, 6'b111000, a, 1'b1, 1'b0, 1'b0));
         q.push_back(mk(b + w + 1, 6'b000100, a, 1'b1, 1'b0, 1'b0));
         if (p_k[i] == K_HALT)
            q.push_back(mk(b + w + 2, 6'b000000, a, 1'b0, 1'b1, 1'b0));
         else if (p_k[i] == K_TRAP)
            q.push_back(mk(b + w + 2, 6'b000000, a, 1'b0, 1'b0, 1'b1));
         else begin
            a = p_alu[i];
            ex = b + w + 2;
            q.push_back(mk(ex, 6'b000010, a, 1'b1, 1'b0, 1'b0));
            if (p_rd[i] != 5'd0 && !(mode == 2 && i == n - 1))
               q.push_back(mk(ex + 1, 6'b000001, a, 1'b1, 1'b0, 1'b0));
            b += w + 4;
         end
      end
      cur_alu = a;
      if (mode != 1) begin
         for (int t = 0; t < 300 && cyc < ex; t++) begin
            @(posedge CLK);
            #1;
         end
         @(negedge CLK);
         if (mode == 0)
            run = 1'b0;
         else begin
            #2;
            RESET = 1'b1;
            run = 1'b0;
            #1;
            chk("async_reset_strobes", 32'({imem_req, ir_write, pc_write, rf_read, alu_latch, reg_write}), 32'd0);
            chk("async_reset_alu_ctl", 32'(alu_ctl), 32'd0);
            chk("async_reset_busy", 32'(busy), 32'd0);
            cur_alu = 4'b0000;
            repeat (2) @(posedge CLK);
            #1;
            RESET = 1'b0;
         end
      end
   endtask

   initial begin
      int exp_ret;
      RESET = 1'b1;
      run = 1'b0;
      for (int i = 0; i < 16; i++) ld(i, 6'b0, 5'b0, 0, K_ALU, 4'b0);
      repeat (2) @(negedge CLK);
      chk("reset_strobes", 32'({imem_req, ir_write, pc_write, rf_read, alu_latch, reg_write}), 32'd0);
      chk("reset_alu_ctl", 32'(alu_ctl), 32'd0);
      chk("reset_status", 32'({busy, halted, trap}), 32'd0);
      chk("reset_retired", 32'(retired), 32'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      chk("idle_no_run_busy", 32'(busy), 32'd0);

      ld(0, 6'b000010, 5'd2, 0, K_ALU, 4'b0010);
      go(1, 0);
      drain("add_drain");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("add_then_idle_busy", 32'(busy), 32'd0);

      ld(0, 6'b000001, 5'd3, 3, K_ALU, 4'b0001);
      go(1, 0);
      drain("wait_drain");

      ld(0, 6'b000000, 5'd0, 0, K_ALU, 4'b0000);
      go(1, 0);
      drain("rd0_drain");
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rd0_then_idle_busy", 32'(busy), 32'd0);
`ifdef MCTRL_PERF_CNT_EN
      exp_ret = 3;
`else
      exp_ret = 0;
`endif
      chk("retired_after_three", 32'(retired), 32'(exp_ret));

      do_reset();
      ld(0, 6'b000010, 5'd2, 0, K_ALU, 4'b0010);
      ld(1, 6'b000000, 5'd1, 0, K_ALU, 4'b0000);
      ld(2, 6'b000001, 5'd3, 0, K_ALU, 4'b0001);
      ld(3, 6'b000110, 5'd4, 2, K_ALU, 4'b0110);
      ld(4, 6'b000111, 5'd5, 0, K_ALU, 4'b0111);
      ld(5, 6'b001100, 5'd6, 0, K_ALU, 4'b1100);
      ld(6, 6'b111111, 5'd0, 0, K_HALT, 4'b0000);
      go(7, 1);
      drain("stream_drain");
      chk("stream_halted", 32'({busy, halted, trap}), 32'b010);
`ifdef MCTRL_PERF_CNT_EN
      exp_ret = 6;
`else
      exp_ret = 0;
`endif
      chk("stream_retired", 32'(retired), 32'(exp_ret));
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("halt_sticky", 32'({imem_req, busy, halted, trap}), 32'b0010);

      do_reset();
      @(negedge CLK);
      chk("halt_cleared", 32'(halted), 32'd0);
      ld(0, 6'b000011, 5'd9, 0, K_TRAP, 4'b0000);
      ld(1, 6'b000010, 5'd1, 0, K_ALU, 4'b0010);
      go(1, 1);
      drain("trap_drain");
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk("trap_sticky", 32'({imem_req, busy, halted, trap}), 32'b0001);
      chk("trap_alu_ctl", 32'(alu_ctl), 32'd0);
      do_reset();
      @(negedge CLK);
      chk("trap_cleared", 32'(trap), 32'd0);

      ld(0, 6'b000110, 5'd7, 1, K_ALU, 4'b0110);
      go(1, 2);
      repeat (6) @(posedge CLK);
      drain("reset_exec_drain");
      chk("reset_exec_status", 32'({busy, halted, trap}), 32'd0);
      chk("reset_exec_retired", 32'(retired), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
